// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit arbiter, lowest-free-slot allocator and gate open/close sequencer for a 15-slot car park.
// Grant one cycle after a request seen in IDLE; requests wait while a gate cycle is in flight. PARK_EXIT_PRIORITY_EN selects fixed exit priority.
module parking_gate_ctrl #(
  parameter int NUM_SLOTS        = 15,
  parameter int GATE_OPEN_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [3:0]           exit_slot,
  input  logic                 car_passed,
  output logic                 entry_ack,
  output logic [3:0]           entry_slot,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic                 gate_open,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [3:0]           count,
  output logic                 full,
  output logic                 empty
);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t               state;
  logic [7:0]           timer;
  logic                 dir;       // 1 = exit operation in flight
  logic [3:0]           exit_lat;
`ifndef PARK_EXIT_PRIORITY_EN
  logic                 last_exit;
`endif

  logic [NUM_SLOTS-1:0] occ_nxt;
  logic [3:0]           cnt_nxt;
  logic [3:0]           free_idx;
  logic                 entry_ok;
  logic                 exit_ok;
  logic                 grant_entry;
  logic                 grant_exit;

  always_comb begin
    entry_ok = entry_req && !full;
    exit_ok  = exit_req && (exit_slot < 4'(NUM_SLOTS)) && occupancy[exit_slot];
`ifdef PARK_EXIT_PRIORITY_EN
    grant_exit  = exit_ok;
    grant_entry = entry_ok && !exit_ok;
`else
    grant_entry = entry_ok && (!exit_ok || last_exit);
    grant_exit  = exit_ok && !grant_entry;
`endif

    // descending scan so the lowest free index is the one left standing
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) free_idx = 4'(i);
    end

    occ_nxt = occupancy;
    if (state == OPEN && car_passed) begin
      if (dir) begin
        if (exit_lat < 4'(NUM_SLOTS)) occ_nxt[exit_lat] = 1'b0;
      end else begin
        if (entry_slot < 4'(NUM_SLOTS)) occ_nxt[entry_slot] = 1'b1;
      end
    end

    cnt_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cnt_nxt = cnt_nxt + {3'b000, occ_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      dir        <= 1'b0;
      exit_lat   <= '0;
`ifndef PARK_EXIT_PRIORITY_EN
      last_exit  <= 1'b1;
`endif
      occupancy  <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      entry_slot <= '0;
      entry_ack  <= 1'b0;
      exit_ack   <= 1'b0;
      exit_err   <= 1'b0;
      gate_open  <= 1'b0;
    end else begin
      entry_ack <= 1'b0;
      exit_ack  <= 1'b0;
      exit_err  <= 1'b0;
      occupancy <= occ_nxt;
      count     <= cnt_nxt;
      full      <= (cnt_nxt == 4'(NUM_SLOTS));
      empty     <= (cnt_nxt == 4'd0);

      case (state)
        IDLE: begin
          exit_err <= exit_req && !exit_ok;
          if (grant_entry) begin
            entry_ack  <= 1'b1;
            entry_slot <= free_idx;
            dir        <= 1'b0;
            timer      <= 8'(GATE_OPEN_CYCLES - 1);
            gate_open  <= 1'b1;
            state      <= OPEN;
`ifndef PARK_EXIT_PRIORITY_EN
            last_exit  <= 1'b0;
`endif
          end else if (grant_exit) begin
            exit_ack  <= 1'b1;
            exit_lat  <= exit_slot;
            dir       <= 1'b1;
            timer     <= 8'(GATE_OPEN_CYCLES - 1);
            gate_open <= 1'b1;
            state     <= OPEN;
`ifndef PARK_EXIT_PRIORITY_EN
            last_exit <= 1'b1;
`endif
          end
        end
        OPEN: begin
          // a pass on the final timed cycle still commits
          if (car_passed || timer == 8'd0) begin
            gate_open <= 1'b0;
            state     <= CLOSE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        CLOSE: state <= IDLE;
        default: begin
          gate_open <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
